// File: rtl/leb128_stream_decoder.sv
// leb128_stream_decoder
// Byte-serial LEB128 decoder. Accepts one encoded byte per cycle on a
// valid/ready stream, assembles the value across cycles and emits one
// decoded value per sequence, with byte count and error flag, on a second
// valid/ready stream.
//
// Parameters:
//   W      : decoded width, 32 or 64
//   SIGNED : 0 = ULEB128 (zero-extend), 1 = SLEB128 (sign-extend)
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_data[7:0]         : bit 7 continuation, bits 6:0 payload
//   in_valid / in_ready  : input handshake (in_ready is combinational)
//   out_data[W-1:0]      : decoded value (0 when out_err)
//   out_len[LW-1:0]      : bytes in the sequence, saturating
//   out_err              : overflow of W or more than N bytes
//   out_valid / out_ready: output handshake
module leb128_stream_decoder #(
  parameter int W      = 32,
  parameter bit SIGNED = 1'b0,
  localparam int N     = (W + 6) / 7,
  localparam int LW    = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] out_len,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready
);

  // Number of payload bits of the last permitted byte that still fall inside W.
  localparam int FB = W - 7 * (N - 1);
  // Payload bits of the last byte that lie at positions >= W.
  localparam logic [6:0] HI_MASK  = 7'(7'h7F << FB);
  // Same bits plus the one that lands on bit W-1 (must all agree when signed).
  localparam logic [6:0] SGN_MASK = 7'(7'h7F << (FB - 1));

  typedef enum logic {ACC, DRAIN} state_t;

  state_t        state;
  logic [W-1:0]  acc;
  logic [LW-1:0] cnt;
  logic          err;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Overflow of the final permitted byte: the bits above W must be a pure
  // zero-extension (unsigned) or sign-extension of bit W-1 (signed).
  function automatic logic last_ovf(input logic [6:0] p);
    return SIGNED ? (((p & SGN_MASK) != 7'd0) && ((p & SGN_MASK) != SGN_MASK))
                  : ((p & HI_MASK) != 7'd0);
  endfunction

  logic          accept;
  logic          cont;
  logic [6:0]    payload;
  logic          last_slot;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  ext_mask;
  logic [W-1:0]  value;
  logic          err_next;
  logic [LW-1:0] len_next;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign cont      = in_data[7];
  assign payload   = in_data[6:0];
  assign last_slot = (cnt == LW'(N - 1));
  assign len_next  = sat_inc(cnt);

  always_comb begin
    acc_next = acc | ({{(W-7){1'b0}}, payload} << (7 * int'(cnt)));
    // Ones above the last payload bit; shifts past W leave the mask empty.
    ext_mask = {W{1'b1}} << (7 * (int'(cnt) + 1));
    value    = acc_next;
    if (SIGNED && payload[6] && !last_slot)
      value = acc_next | ext_mask;
    err_next = err | (last_slot && (cont || last_ovf(payload)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // A consumed result drops valid unless a new one is loaded below.
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        unique case (state)
          ACC: begin
            if (!cont) begin
              out_data  <= err_next ? '0 : value;
              out_len   <= len_next;
              out_err   <= err_next;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              err       <= 1'b0;
            end else begin
              acc <= acc_next;
              cnt <= len_next;
              err <= err_next;
              if (last_slot)
                state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!cont) begin
              out_data  <= '0;
              out_len   <= len_next;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              err       <= 1'b0;
              state     <= ACC;
            end else begin
              cnt <= len_next;
            end
          end
          default: state <= ACC;
        endcase
      end
    end
  end

endmodule
